// File: rtl/sar_pkg.sv
// Shared types and constants for the successive-approximation search controller.
package sar_pkg;

    localparam int SAR_WIDTH = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PROBE = 2'd1,
        DONE  = 2'd2
    } sar_state_t;

endpackage

// File: rtl/sar_search_ctrl_if.sv
// Bundle of the start handshake, comparator flags and result signals of sar_search_ctrl.
// master = the search controller, slave = the initiator / comparator side.
interface sar_search_ctrl_if #(parameter int WIDTH = sar_pkg::SAR_WIDTH);

    logic             start;
    logic             cmp_eq;
    logic             cmp_gt;
    logic             cmp_lt;
    logic [WIDTH-1:0] guess;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             err;

    modport master (
        input  start, cmp_eq, cmp_gt, cmp_lt,
        output guess, busy, done, result, err
    );

    modport slave (
        output start, cmp_eq, cmp_gt, cmp_lt,
        input  guess, busy, done, result, err
    );

endinterface

// File: rtl/sar_search_ctrl.sv
// MSB-first successive-approximation search driving a combinational magnitude comparator.
// Optional macro CMP_CHECK_EN: abort with err=1 when the comparator flags are not one-hot.
module sar_search_ctrl
    import sar_pkg::*;
#(
    parameter  int WIDTH = SAR_WIDTH,
    localparam int IDX_W = $clog2(WIDTH)
) (
    input  logic              clk,
    input  logic              rst,
    sar_search_ctrl_if.master bus
);

    sar_state_t       state_reg, state_next;
    logic [WIDTH-1:0] guess_reg, guess_next;
    logic [IDX_W-1:0] idx_reg, idx_next;
    logic             done_reg, done_next;
    logic [WIDTH-1:0] result_reg, result_next;
    logic             err_reg, err_next;
    logic [WIDTH-1:0] kept;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= IDLE;
            guess_reg  <= '0;
            idx_reg    <= IDX_W'(WIDTH - 1);
            done_reg   <= 1'b0;
            result_reg <= '0;
            err_reg    <= 1'b0;
        end else begin
            state_reg  <= state_next;
            guess_reg  <= guess_next;
            idx_reg    <= idx_next;
            done_reg   <= done_next;
            result_reg <= result_next;
            err_reg    <= err_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        guess_next  = guess_reg;
        idx_next    = idx_reg;
        done_next   = 1'b0;
        result_next = result_reg;
        err_next    = err_reg;
        kept        = guess_reg;

        case (state_reg)
            IDLE, DONE: begin
                // A start coinciding with the done pulse is dropped.
                if (bus.start && !done_reg) begin
                    state_next = PROBE;
                    guess_next = WIDTH'(1) << (WIDTH - 1);
                    idx_next   = IDX_W'(WIDTH - 1);
                    err_next   = 1'b0;
                end
            end
            PROBE: begin
`ifdef CMP_CHECK_EN
                if (!$onehot({bus.cmp_eq, bus.cmp_gt, bus.cmp_lt})) begin
                    err_next    = 1'b1;
                    result_next = guess_reg;
                    state_next  = DONE;
                    done_next   = 1'b1;
                end else
`endif
                if (bus.cmp_eq) begin
                    result_next = guess_reg;
                    state_next  = DONE;
                    done_next   = 1'b1;
                end else begin
                    // lt clears the trial bit; gt (or no flag) keeps it.
                    if (bus.cmp_lt) begin
                        kept[idx_reg] = 1'b0;
                    end
                    if (idx_reg != '0) begin
                        guess_next = kept | (WIDTH'(1) << (idx_reg - IDX_W'(1)));
                        idx_next   = idx_reg - IDX_W'(1);
                    end else begin
                        result_next = kept;
                        state_next  = DONE;
                        done_next   = 1'b1;
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign bus.guess  = guess_reg;
    assign bus.busy   = (state_reg == PROBE);
    assign bus.done   = done_reg;
    assign bus.result = result_reg;
    assign bus.err    = err_reg;

endmodule

// File: tb/tb_sar_search_ctrl.sv
// Self-checking bench for sar_search_ctrl: directed table, hand sequences and random targets
// checked against a binary-search reference model.
module tb_sar_search_ctrl;

    localparam int W = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    sar_search_ctrl_if #(.WIDTH(W)) bus ();

    sar_search_ctrl #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Comparator partner; the fault forces gt and lt together while guess is 12.
    logic [W-1:0] target  = '0;
    bit           fault_en = 1'b0;
    logic         flt_now;
    assign flt_now    = fault_en && bus.busy && (bus.guess == 4'd12);
    assign bus.cmp_eq = flt_now ? 1'b0 : (target == bus.guess);
    assign bus.cmp_gt = flt_now ? 1'b1 : (target >  bus.guess);
    assign bus.cmp_lt = flt_now ? 1'b1 : (target <  bus.guess);

    int n_checks = 0;
    int n_fail   = 0;

    int exp_g[$];
    int model_res;
    bit model_err;

    task automatic chk(input string name, input int act, input int req);
        n_checks++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    // Binary search: step halves each probe; the last probe (step 0) resolves bit 0.
    task automatic model(input int tgt, input bit flt);
        int  g;
        int  step;
        bit  less;
        bit  eq;
        g    = 1 << (W - 1);
        step = 1 << (W - 2);
        exp_g.delete();
        model_err = 1'b0;
        forever begin
            exp_g.push_back(g);
            eq   = (tgt == g);
            less = (tgt < g);
            if (flt && g == 12) begin
`ifdef CMP_CHECK_EN
                model_err = 1'b1;
                model_res = g;
                return;
`else
                eq   = 1'b0;
                less = 1'b1;
`endif
            end
            if (eq) begin
                model_res = g;
                return;
            end
            if (step == 0) begin
                model_res = less ? g - 1 : g;
                return;
            end
            g    = less ? g - step : g + step;
            step = step / 2;
        end
    endtask

    // Entered and left on a negative edge; poke asserts start during PROBE and in the done cycle.
    task automatic run_search(input int tgt, input bit flt, input int exp_res, input int exp_cyc,
                              input bit exp_err, input bit poke);
        int  cyc;
        bit  seen;
        logic [W-1:0] last_guess;
        model(tgt, flt);
        target    = W'(tgt);
        fault_en  = flt;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        cyc  = 1;
        seen = 1'b0;
        while (cyc <= W + 2) begin
            if (bus.done) begin
                seen = 1'b1;
                break;
            end
            chk("busy_in_probe", int'(bus.busy), 1);
            if (cyc - 1 < exp_g.size())
                chk("guess_seq", int'(bus.guess), exp_g[cyc-1]);
            else
                chk("probe_overrun", cyc, exp_g.size());
            bus.start = (poke && cyc == 1) ? 1'b1 : 1'b0;
            @(negedge clk);
            bus.start = 1'b0;
            cyc++;
        end
        chk("done_seen", int'(seen), 1);
        chk("latency", cyc, exp_cyc);
        chk("latency_model", cyc, exp_g.size() + 1);
        chk("result", int'(bus.result), exp_res);
        chk("result_model", int'(bus.result), model_res);
        chk("err", int'(bus.err), int'(exp_err));
        chk("err_model", int'(bus.err), int'(model_err));
        chk("busy_at_done", int'(bus.busy), 0);
        $display("search target=%0d fault=%0d cycles=%0d result=%0d err=%0d", tgt, flt, cyc,
                 bus.result, bus.err);
        last_guess = bus.guess;
        bus.start  = poke;
        @(negedge clk);
        bus.start = 1'b0;
        chk("done_pulse_width", int'(bus.done), 0);
        chk("busy_after_done", int'(bus.busy), 0);
        chk("guess_held", int'(bus.guess), int'(last_guess));
        fault_en = 1'b0;
    endtask

    typedef struct {
        int tgt;
        bit flt;
        int exp_res;
        int exp_cyc;
        bit exp_err;
        bit poke;
    } vec_t;

    vec_t vecs[7];

    initial begin
        vecs[0] = '{tgt: 11, flt: 0, exp_res: 11, exp_cyc: 5, exp_err: 0, poke: 0};
        vecs[1] = '{tgt: 0,  flt: 0, exp_res: 0,  exp_cyc: 5, exp_err: 0, poke: 0};
        vecs[2] = '{tgt: 8,  flt: 0, exp_res: 8,  exp_cyc: 2, exp_err: 0, poke: 0};
        vecs[3] = '{tgt: 15, flt: 0, exp_res: 15, exp_cyc: 5, exp_err: 0, poke: 0};
        vecs[4] = '{tgt: 15, flt: 0, exp_res: 15, exp_cyc: 5, exp_err: 0, poke: 0};
        vecs[5] = '{tgt: 6,  flt: 0, exp_res: 6,  exp_cyc: 4, exp_err: 0, poke: 1};
`ifdef CMP_CHECK_EN
        vecs[6] = '{tgt: 13, flt: 1, exp_res: 12, exp_cyc: 3, exp_err: 1, poke: 0};
`else
        vecs[6] = '{tgt: 13, flt: 1, exp_res: 11, exp_cyc: 5, exp_err: 0, poke: 0};
`endif

        bus.start = 1'b0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_guess",  int'(bus.guess),  0);
        chk("reset_busy",   int'(bus.busy),   0);
        chk("reset_done",   int'(bus.done),   0);
        chk("reset_result", int'(bus.result), 0);
        chk("reset_err",    int'(bus.err),    0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 7; i++)
            run_search(vecs[i].tgt, vecs[i].flt, vecs[i].exp_res, vecs[i].exp_cyc,
                       vecs[i].exp_err, vecs[i].poke);

        // Reset during the second probe of a target=5 search.
        target    = 4'd5;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_guess",  int'(bus.guess),  0);
        chk("midrst_busy",   int'(bus.busy),   0);
        chk("midrst_done",   int'(bus.done),   0);
        chk("midrst_result", int'(bus.result), 0);
        chk("midrst_err",    int'(bus.err),    0);
        $display("reset mid-search target=5 guess=%0d busy=%0d result=%0d", bus.guess, bus.busy,
                 bus.result);
        @(negedge clk);
        run_search(5, 1'b0, 5, 5, 1'b0, 1'b0);

        for (int i = 0; i < 30; i++) begin
            int t;
            bit f;
            t = int'($urandom_range(0, 15));
            f = ($urandom_range(0, 3) == 0);
            model(t, f);
            run_search(t, f, model_res, exp_g.size() + 1, model_err, bit'($urandom_range(0, 1)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule
